// File: rtl/channel_frame_latch_pkg.sv
// Shared definitions for the channel frame latch: sync marker, CRC polynomial,
// receive FSM encoding and payload length helper.
package channel_frame_latch_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CRC8_POLY     = 8'h07;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    // Payload bytes needed to carry num_ch channel bits.
    function automatic int nbytes(input int num_ch);
        return (num_ch + 7) / 8;
    endfunction

endpackage

// File: rtl/crc8_byte_update.sv
// One-byte CRC-8 step (MSB first, no reflection); purely combinational.
module crc8_byte_update
    import channel_frame_latch_pkg::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [7:0] c;

    always_comb begin
        c = crc_i ^ data_i;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        crc_o = c;
    end

endmodule

// File: rtl/channel_frame_latch.sv
// Frame receiver: hunts sync, collects payload, checks CRC-8 into a shadow register;
// PORT reloads from shadow on each sync_pulse rising edge. All outputs registered.
module channel_frame_latch
    import channel_frame_latch_pkg::*;
#(
    parameter int         NUM_CH         = 12,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              rx_error,
    input  logic              sync_pulse,
    output logic [NUM_CH-1:0] PORT,
    output logic              need_data,
    output logic              incorrect_data,
    output logic              frame_ok
);

    localparam int NBYTES = nbytes(NUM_CH);
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         crc_q;
    logic [7:0]         crc_d;
    logic [TMO_W-1:0]   tmo_q;
    logic [NUM_CH-1:0]  payload_q;
    logic [NUM_CH-1:0]  payload_d;
    logic [NUM_CH-1:0]  shadow_q;
    logic [NUM_CH-1:0]  port_q;
    logic               sync_q;
    logic               need_q;
    logic               inc_q;
    logic               ok_q;
    logic               sync_edge;

    assign sync_edge = sync_pulse & ~sync_q;

    crc8_byte_update u_crc (
        .crc_i  (crc_q),
        .data_i (rx_byte),
        .crc_o  (crc_d)
    );

    // Only channel bits are kept; unused high bits of the last byte feed the CRC only.
    always_comb begin
        payload_d = payload_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_q == CNT_W'(i / 8)) begin
                payload_d[IDX_W'(i)] = rx_byte[3'(i % 8)];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_HUNT;
            cnt_q     <= '0;
            crc_q     <= '0;
            tmo_q     <= '0;
            payload_q <= '0;
            shadow_q  <= '0;
            port_q    <= '0;
            sync_q    <= 1'b0;
            need_q    <= 1'b1;
            inc_q     <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            sync_q <= sync_pulse;
            ok_q   <= 1'b0;

            // Port loads the pre-capture shadow; a same-cycle capture overrides need_data below.
            if (sync_edge) begin
                port_q <= shadow_q;
                need_q <= 1'b1;
            end

            case (state_q)
                ST_HUNT: begin
                    if (rx_valid && rx_byte == SYNC_BYTE) begin
                        state_q <= ST_PAYLOAD;
                        crc_q   <= '0;
                        cnt_q   <= '0;
                        tmo_q   <= '0;
                    end
                end
                ST_PAYLOAD, ST_CHECK: begin
                    if (rx_error) begin
                        state_q <= ST_HUNT;
                        inc_q   <= 1'b1;
                    end else if (rx_valid) begin
                        tmo_q <= '0;
                        if (state_q == ST_PAYLOAD) begin
                            payload_q <= payload_d;
                            crc_q     <= crc_d;
                            cnt_q     <= cnt_q + 1'b1;
                            if (cnt_q == CNT_W'(NBYTES - 1)) begin
                                state_q <= ST_CHECK;
                            end
                        end else begin
                            state_q <= ST_HUNT;
                            if (rx_byte == crc_q) begin
                                shadow_q <= payload_q;
                                ok_q     <= 1'b1;
                                need_q   <= 1'b0;
                                inc_q    <= 1'b0;
                            end else begin
                                inc_q <= 1'b1;
                            end
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= ST_HUNT;
                        inc_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= ST_HUNT;
            endcase
        end
    end

    assign PORT           = port_q;
    assign need_data      = need_q;
    assign incorrect_data = inc_q;
    assign frame_ok       = ok_q;

endmodule
